vga_dither_pipe: RTL



---
 rtl/vga_dither_pkg.sv | 25 ++
 rtl/vga_dither_pipe_if.sv | 21 ++
 rtl/vga_dither_pipe_quant.sv | 21 ++
 rtl/vga_dither_pipe.sv | 76 +++++++
 4 files changed

// File: rtl/vga_dither_pkg.sv
// vga_dither_pkg: mode encodings and Bayer threshold generator for the dither pipe
package vga_dither_pkg;
  localparam logic [1:0] MODE_TRUNC    = 2'd0;
  localparam logic [1:0] MODE_SPATIAL  = 2'd1;
  localparam logic [1:0] MODE_TEMPORAL = 2'd2;
  localparam logic [1:0] MODE_THRESH   = 2'd3;
  localparam int MAX_K = 3;
  // Bit pairs {bx[j], bi[j]} are shifted in LSB-first, so j=0 ends up in the top pair.
  function automatic logic [2*MAX_K-1:0] bayer_thresh(input logic [MAX_K-1:0] bi,
                                                       input logic [MAX_K-1:0] by,
                                                       input int k);
    logic [MAX_K-1:0] bx, b;
    logic [2*MAX_K-1:0] t;
    bx = bi ^ by;
    b  = bi;
    t  = '0;
    for (int j = 0; j < MAX_K; j++)
      if (j < k) begin
        t  = {t[2*MAX_K-3:0], bx[0], b[0]};
        bx = bx >> 1;
        b  = b >> 1;
      end
    return t;
  endfunction
endpackage

// File: rtl/vga_dither_pipe_if.sv
// vga_dither_pipe_if: pixel-in / pixel-out bundle between palette logic and the pins
interface vga_dither_pipe_if #(
  parameter int IN_W       = 5,
  parameter int OUT_W      = 2,
  parameter int BAYER_LOG2 = 2
);
  logic [IN_W-1:0]       in_r, in_g, in_b;
  logic                  in_active, in_hsync, in_vsync;
  logic [BAYER_LOG2-1:0] in_x, in_y;
  logic [1:0]            mode;
  logic [OUT_W-1:0]      out_r, out_g, out_b;
  logic                  out_hsync, out_vsync;
  modport master (
    output in_r, in_g, in_b, in_active, in_hsync, in_vsync, in_x, in_y, mode,
    input  out_r, out_g, out_b, out_hsync, out_vsync
  );
  modport slave (
    input  in_r, in_g, in_b, in_active, in_hsync, in_vsync, in_x, in_y, mode,
    output out_r, out_g, out_b, out_hsync, out_vsync
  );
endinterface

// File: rtl/vga_dither_pipe_quant.sv
// dither_quant: one channel's threshold-biased rescale to OUT_W bits with clamp
module dither_quant #(
  parameter int IN_W  = 5,
  parameter int OUT_W = 2,
  parameter int T     = 4
) (
  input  logic [IN_W-1:0]  v,
  input  logic [T-1:0]     t,
  output logic [OUT_W-1:0] q
);
  localparam int AW = IN_W + OUT_W + T + 1;
  localparam logic [AW-1:0] L = AW'((1 << OUT_W) - 1);
  logic [AW-1:0] vp, acc, lvl;
  // v' stretches full-scale input to exactly 2^IN_W so the top code maps to L
  always_comb begin
    vp  = AW'(v) + AW'(v >> (IN_W - 1));
    acc = ((vp * L) << T) + (AW'(t) << IN_W);
    lvl = acc >> (IN_W + T);
    q   = lvl > L ? OUT_W'(L) : OUT_W'(lvl);
  end
endmodule

// File: rtl/vga_dither_pipe.sv
// vga_dither_pipe: two-stage ordered-dither output stage with aligned sync delay
module vga_dither_pipe
  import vga_dither_pkg::*;
#(
  parameter int IN_W       = 5,
  parameter int OUT_W      = 2,
  parameter int BAYER_LOG2 = 2
) (
  input logic clk,
  input logic rst_n,
  vga_dither_pipe_if.slave px
);
  localparam int K = BAYER_LOG2;
  localparam int T = 2 * K;
  logic             vs_q, frame_ev, ox, oy, act1, hs1, vs1;
  logic [1:0]       frame, mode_q, mode1;
  logic [T-1:0]     t0, t1;
  logic [IN_W-1:0]  r1, g1, b1;
  logic [OUT_W-1:0] qr, qg, qb, tv;
  assign frame_ev = px.in_vsync & ~vs_q;
  assign ox = (mode_q == MODE_TEMPORAL) & frame[0];
  assign oy = (mode_q == MODE_TEMPORAL) & frame[1];
  assign t0 = T'(bayer_thresh(MAX_K'(px.in_x ^ {K{ox}}), MAX_K'(px.in_y ^ {K{oy}}), K));
  assign tv = OUT_W'(t1 >> (T - OUT_W));
  function automatic logic [OUT_W-1:0] pick(input logic [IN_W-1:0] v, input logic [OUT_W-1:0] q);
    return !act1 ? '0 : mode1 == MODE_TRUNC ? OUT_W'(v >> (IN_W - OUT_W)) : mode1 == MODE_THRESH ? tv : q;
  endfunction
  // Frame counter and mode only move on a vsync rising edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vs_q   <= 1'b0;
      frame  <= '0;
      mode_q <= MODE_TRUNC;
    end else begin
      vs_q <= px.in_vsync;
      if (frame_ev) begin
        frame  <= frame + 2'd1;
        mode_q <= px.mode;
      end
    end
  // Stage 1: capture pixel, syncs, threshold and the mode it was computed under
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {r1, g1, b1} <= '0;
      {act1, hs1, vs1} <= '0;
      t1    <= '0;
      mode1 <= MODE_TRUNC;
    end else begin
      r1    <= px.in_r;
      g1    <= px.in_g;
      b1    <= px.in_b;
      act1  <= px.in_active;
      hs1   <= px.in_hsync;
      vs1   <= px.in_vsync;
      t1    <= t0;
      mode1 <= mode_q;
    end
  dither_quant #(.IN_W(IN_W), .OUT_W(OUT_W), .T(T)) u_qr (.v(r1), .t(t1), .q(qr));
  dither_quant #(.IN_W(IN_W), .OUT_W(OUT_W), .T(T)) u_qg (.v(g1), .t(t1), .q(qg));
  dither_quant #(.IN_W(IN_W), .OUT_W(OUT_W), .T(T)) u_qb (.v(b1), .t(t1), .q(qb));
  // Stage 2: mode select and blanking; syncs pass ungated
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      px.out_r     <= '0;
      px.out_g     <= '0;
      px.out_b     <= '0;
      px.out_hsync <= 1'b0;
      px.out_vsync <= 1'b0;
    end else begin
      px.out_r     <= pick(r1, qr);
      px.out_g     <= pick(g1, qg);
      px.out_b     <= pick(b1, qb);
      px.out_hsync <= hs1;
      px.out_vsync <= vs1;
    end
endmodule
